// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: serial input, qualifier, clear and match outputs of one detector
interface seq_detector_param_if #(
    parameter int CW = 8
);
    logic clear;
    logic en;
    logic j;
    logic w_mealy;
    logic w_moore;
    logic [CW-1:0] count;
    modport master (output clear, en, j, input w_mealy, w_moore, count);
    modport slave (input clear, en, j, output w_mealy, w_moore, count);
endinterface

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial pattern detector with Mealy/Moore flags and saturating match count
module seq_detector_param #(
    parameter int N = 4,
    parameter logic [N-1:0] PATTERN = 4'b1001,
    parameter bit OVERLAP = 1'b1,
    parameter int CW = 8
) (
    input logic clock,
    input logic reset,
    seq_detector_param_if.slave bus
);
    localparam int FW = $clog2(N + 1);
    logic [N-1:0] hist_q;
    logic [N-1:0] hist_d;
    logic [FW-1:0] fill_q;
    logic [FW-1:0] fill_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic moore_q;
    logic hit;
    // a hit needs N-1 genuinely received bits plus the current one; reset and clear mask it
    always_comb begin
        hit = bus.en & ~bus.clear & ~reset & (fill_q >= FW'(N - 1)) & ({hist_q[N-2:0], bus.j} == PATTERN);
        hist_d = bus.en ? {hist_q[N-2:0], bus.j} : hist_q;
        fill_d = !bus.en ? fill_q : (hit && !OVERLAP) ? '0 : (fill_q == FW'(N)) ? fill_q : fill_q + 1'b1;
        count_d = (hit && count_q != '1) ? count_q + 1'b1 : count_q;
    end
    // reset and clear wipe all history so partial matches never survive them
    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            hist_q <= '0;
            fill_q <= '0;
            count_q <= '0;
            moore_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            count_q <= count_d;
            moore_q <= hit;
        end
    end
    assign bus.w_mealy = hit;
    assign bus.w_moore = moore_q;
    assign bus.count = count_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of overlap, non-overlap, stall, warm-up, reset/clear and saturation
module tb_seq_detector_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic en = 1'b0;
    logic j = 1'b0;
    int checks = 0;
    int fails = 0;
    bit [12:0] s1 = 13'b1001001000100;
    bit [6:0] sj = 7'b1010101;
    bit [6:0] se = 7'b1100011;
    int k_exp;

    always #5 clock = ~clock;

    seq_detector_param_if #(.CW(8)) ifa ();
    seq_detector_param_if #(.CW(8)) ifb ();
    seq_detector_param_if #(.CW(8)) ifc ();
    seq_detector_param_if #(.CW(2)) ifd ();

    assign ifa.clear = clear;
    assign ifa.en = en;
    assign ifa.j = j;
    assign ifb.clear = clear;
    assign ifb.en = en;
    assign ifb.j = j;
    assign ifc.clear = clear;
    assign ifc.en = en;
    assign ifc.j = j;
    assign ifd.clear = clear;
    assign ifd.en = en;
    assign ifd.j = j;

    seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b1), .CW(8)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
    seq_detector_param #(.N(4), .PATTERN(4'b1001), .OVERLAP(1'b0), .CW(8)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));
    seq_detector_param #(.N(4), .PATTERN(4'b0001), .OVERLAP(1'b1), .CW(8)) dut_c (.clock(clock), .reset(reset), .bus(ifc.slave));
    seq_detector_param #(.N(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CW(2)) dut_d (.clock(clock), .reset(reset), .bus(ifd.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic jv, input logic ev, input logic cv, input logic rv);
        @(negedge clock);
        j = jv;
        en = ev;
        clear = cv;
        reset = rv;
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("rst_mealy", 32'(ifa.w_mealy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_count_a", 32'(ifa.count), 32'd0);
        chk("rst_moore_a", 32'(ifa.w_moore), 32'd0);
        chk("rst_count_d", 32'(ifd.count), 32'd0);
        for (int i = 0; i < 13; i++) begin
            drive(s1[12-i], 1'b1, 1'b0, 1'b0);
            chk("ovl_mealy", 32'(ifa.w_mealy), 32'(i == 3 || i == 6));
            chk("ovl_moore", 32'(ifa.w_moore), 32'(i == 4 || i == 7));
            chk("novl_mealy", 32'(ifb.w_mealy), 32'(i == 3));
            chk("novl_moore", 32'(ifb.w_moore), 32'(i == 4));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovl_count", 32'(ifa.count), 32'd2);
        chk("novl_count", 32'(ifb.count), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(sj[6-i], se[6-i], 1'b0, 1'b0);
            if (i == 0) chk("clr_count", 32'(ifa.count), 32'd0);
            chk("stall_mealy", 32'(ifa.w_mealy), 32'(i == 6));
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_moore", 32'(ifa.w_moore), 32'd1);
        chk("stall_count", 32'(ifa.count), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_moore_drop", 32'(ifa.w_moore), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("warm_mealy", 32'(ifc.w_mealy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("warm_early", 32'(ifc.w_mealy), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("warm_hit", 32'(ifc.w_mealy), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("warm_moore", 32'(ifc.w_moore), 32'd1);
        chk("warm_count", 32'(ifc.count), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        chk("midrst_mealy", 32'(ifa.w_mealy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_moore", 32'(ifa.w_moore), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clrhit_mealy", 32'(ifa.w_mealy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("clrhit_moore", 32'(ifa.w_moore), 32'd0);
        chk("clrhit_count", 32'(ifa.count), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            k_exp = (k <= 2) ? 0 : (k - 2 > 3) ? 3 : k - 2;
            chk("sat_mealy", 32'(ifd.w_mealy), 32'(k >= 2));
            chk("sat_moore", 32'(ifd.w_moore), 32'(k >= 3));
            chk("sat_count", 32'(ifd.count), 32'(k_exp));
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sat_final_count", 32'(ifd.count), 32'd3);
        chk("sat_final_moore", 32'(ifd.w_moore), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
